// File: rtl/cla_pkg.sv
// cla_pkg: shared width and grouping constants for the 32-bit lookahead adder/subtractor
package cla_pkg;
  localparam int CLA_WIDTH   = 32;
  localparam int CLA_GROUP   = 4;
  localparam int CLA_NGROUPS = CLA_WIDTH / CLA_GROUP;
endpackage

// File: rtl/cla_4.sv
// cla_4: 4-bit lookahead group (a,b,cin -> s, group generate G, group propagate P, carry into top bit c3)
module cla_4
  import cla_pkg::*;
(
  input  logic [CLA_GROUP-1:0] a,
  input  logic [CLA_GROUP-1:0] b,
  input  logic                 cin,
  output logic [CLA_GROUP-1:0] s,
  output logic                 G,
  output logic                 P,
  output logic                 c3
);
  logic [CLA_GROUP-1:0] g, p;
  logic c1, c2;
  assign g  = a & b;
  assign p  = a ^ b;
  assign c1 = g[0] | (p[0] & cin);
  assign c2 = g[1] | (p[1] & g[0]) | (&p[1:0] & cin);
  assign c3 = g[2] | (p[2] & g[1]) | (&p[2:1] & g[0]) | (&p[2:0] & cin);
  assign G  = g[3] | (p[3] & g[2]) | (&p[3:2] & g[1]) | (&p[3:1] & g[0]);
  assign P  = &p;
  assign s  = p ^ {c3, c2, c1, cin};
endmodule

// File: rtl/cla_32_addsub.sv
// cla_32_addsub: two-level CLA add/sub (src1, src2, sub_flag -> sum, carry_out, overflow, plus registered _r copies)
module cla_32_addsub
  import cla_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CLA_WIDTH-1:0] src1,
  input  logic [CLA_WIDTH-1:0] src2,
  input  logic                 sub_flag,
  output logic [CLA_WIDTH-1:0] sum,
  output logic                 carry_out,
  output logic                 overflow,
  output logic [CLA_WIDTH-1:0] sum_r,
  output logic                 carry_out_r,
  output logic                 overflow_r
);
  logic [CLA_WIDTH-1:0]   b;
  logic [CLA_NGROUPS-1:0] G, P, c3_v;
  logic [CLA_NGROUPS:0]   c;
  logic [CLA_WIDTH-1:0]   sum_q;
  logic                   carry_out_q, overflow_q;
  logic                   unused_c3;
  assign b    = src2 ^ {CLA_WIDTH{sub_flag}};
  assign c[0] = sub_flag;
  assign c[1] = G[0] | (P[0] & c[0]);
  assign c[2] = G[1] | (P[1] & G[0]) | (&P[1:0] & c[0]);
  assign c[3] = G[2] | (P[2] & G[1]) | (&P[2:1] & G[0]) | (&P[2:0] & c[0]);
  assign c[4] = G[3] | (P[3] & G[2]) | (&P[3:2] & G[1]) | (&P[3:1] & G[0]) | (&P[3:0] & c[0]);
  assign c[5] = G[4] | (P[4] & G[3]) | (&P[4:3] & G[2]) | (&P[4:2] & G[1]) | (&P[4:1] & G[0])
              | (&P[4:0] & c[0]);
  assign c[6] = G[5] | (P[5] & G[4]) | (&P[5:4] & G[3]) | (&P[5:3] & G[2]) | (&P[5:2] & G[1])
              | (&P[5:1] & G[0]) | (&P[5:0] & c[0]);
  assign c[7] = G[6] | (P[6] & G[5]) | (&P[6:5] & G[4]) | (&P[6:4] & G[3]) | (&P[6:3] & G[2])
              | (&P[6:2] & G[1]) | (&P[6:1] & G[0]) | (&P[6:0] & c[0]);
  assign c[8] = G[7] | (P[7] & G[6]) | (&P[7:6] & G[5]) | (&P[7:5] & G[4]) | (&P[7:4] & G[3])
              | (&P[7:3] & G[2]) | (&P[7:2] & G[1]) | (&P[7:1] & G[0]) | (&P[7:0] & c[0]);
  for (genvar i = 0; i < CLA_NGROUPS; i++) begin : g_grp
    cla_4 u_cla_4 (
      .a  (src1[CLA_GROUP*i +: CLA_GROUP]),
      .b  (b[CLA_GROUP*i +: CLA_GROUP]),
      .cin(c[i]),
      .s  (sum[CLA_GROUP*i +: CLA_GROUP]),
      .G  (G[i]),
      .P  (P[i]),
      .c3 (c3_v[i])
    );
  end
  // only the top group's carry into bit 31 feeds overflow
  assign unused_c3 = &{1'b0, c3_v[CLA_NGROUPS-2:0]};
  assign carry_out = c[CLA_NGROUPS];
  assign overflow  = c3_v[CLA_NGROUPS-1] ^ c[CLA_NGROUPS];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q       <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      sum_q       <= sum;
      carry_out_q <= carry_out;
      overflow_q  <= overflow;
    end
  end
  assign sum_r       = sum_q;
  assign carry_out_r = carry_out_q;
  assign overflow_r  = overflow_q;
endmodule

// File: tb/tb_cla_32_addsub.sv
// tb_cla_32_addsub: directed and random self-checking bench for cla_32_addsub
module tb_cla_32_addsub;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] src1 = '0, src2 = '0;
  logic        sub_flag = 1'b0;
  logic [31:0] sum, sum_r;
  logic        carry_out, overflow, carry_out_r, overflow_r;
  int checks = 0;
  int errors = 0;
  typedef struct {
    logic [31:0] a, b;
    logic        s;
    logic [31:0] sum;
    logic        co, ov;
  } vec_t;
  vec_t vecs [10] = '{
    '{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0},
    '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0},
    '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1},
    '{32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0},
    '{32'h0000_0005, 32'h0000_0005, 1'b1, 32'h0000_0000, 1'b1, 1'b0},
    '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1},
    '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0},
    '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1},
    '{32'h0000_0000, 32'h8000_0000, 1'b1, 32'h8000_0000, 1'b0, 1'b1},
    '{32'h0F0F_0F0F, 32'h0101_0101, 1'b0, 32'h1010_1010, 1'b0, 1'b0}
  };
  cla_32_addsub dut (
    .clk        (clk),
    .rst        (rst),
    .src1       (src1),
    .src2       (src2),
    .sub_flag   (sub_flag),
    .sum        (sum),
    .carry_out  (carry_out),
    .overflow   (overflow),
    .sum_r      (sum_r),
    .carry_out_r(carry_out_r),
    .overflow_r (overflow_r)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [33:0] got, input logic [33:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic rand_vec(input logic s);
    logic [32:0] r;
    logic        ov;
    src1     = $urandom;
    src2     = $urandom;
    sub_flag = s;
    r  = s ? {1'b0, src1} + {1'b0, ~src2} + 33'd1 : {1'b0, src1} + {1'b0, src2};
    ov = s ? (src1[31] != src2[31]) && (r[31] != src1[31])
           : (src1[31] == src2[31]) && (r[31] != src1[31]);
    #1;
    check(s ? "rand_sub" : "rand_add", {carry_out, overflow, sum}, {r[32], ov, r[31:0]});
  endtask
  initial begin
    @(negedge clk);
    check("rst_sum_r", {2'b0, sum_r}, 34'd0);
    check("rst_flags_r", {32'b0, carry_out_r, overflow_r}, 34'd0);
    src1 = 32'd5;
    src2 = 32'd3;
    #1;
    check("comb_in_rst", {2'b0, sum}, 34'd8);
    rst = 1'b0;
    foreach (vecs[k]) begin
      @(negedge clk);
      src1     = vecs[k].a;
      src2     = vecs[k].b;
      sub_flag = vecs[k].s;
      #1;
      check($sformatf("sum%0d", k), {2'b0, sum}, {2'b0, vecs[k].sum});
      check($sformatf("co%0d", k), {33'b0, carry_out}, {33'b0, vecs[k].co});
      check($sformatf("ov%0d", k), {33'b0, overflow}, {33'b0, vecs[k].ov});
      @(posedge clk);
      #1;
      check($sformatf("reg%0d", k), {carry_out_r, overflow_r, sum_r},
            {vecs[k].co, vecs[k].ov, vecs[k].sum});
    end
    for (int n = 0; n < 10001; n++) rand_vec(1'b0);
    for (int n = 0; n < 10001; n++) rand_vec(1'b1);
    @(negedge clk);
    src1     = 32'hFFFF_FFFF;
    src2     = 32'h8000_0000;
    sub_flag = 1'b0;
    @(posedge clk);
    #1;
    check("pre_rst_reg", {carry_out_r, overflow_r, sum_r}, {1'b1, 1'b1, 32'h7FFF_FFFF});
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_reg", {carry_out_r, overflow_r, sum_r}, 34'd0);
    src1 = 32'hFFFF_FFFF;
    src2 = 32'h0000_0001;
    #1;
    check("comb_track_rst", {carry_out, overflow, sum}, {1'b1, 1'b0, 32'h0});
    @(posedge clk);
    #1;
    check("rst_hold_reg", {carry_out_r, overflow_r, sum_r}, 34'd0);
    @(negedge clk);
    rst  = 1'b0;
    src1 = 32'h1234_5678;
    src2 = 32'h1111_1111;
    #1;
    check("post_rst_no_edge", {2'b0, sum_r}, 34'd0);
    @(posedge clk);
    #1;
    check("post_rst_sum_r", {2'b0, sum_r}, {2'b0, 32'h2345_6789});
    check("post_rst_co_r", {33'b0, carry_out_r}, 34'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
